// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the decode-side hazard/sequencing controller and the pipeline.
// The slave side is the controller; the master side drives ID/EX/MEM/WB status.
interface pipe_ctrl_if;
  logic        id_valid;
  logic        id_rs1_re;
  logic [4:0]  id_rs1;
  logic        id_rs2_re;
  logic [4:0]  id_rs2;
  logic        id_rd_we;
  logic [4:0]  id_rd;
  logic        id_ebreak;
  logic        ex_redirect;
  logic        mem_busy;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        stall_if_id;
  logic        bubble_id_ex;
  logic        flush_if_id;
  logic        freeze;
  logic        halt;
  logic [31:0] busy_vec;

  modport master (
    output id_valid, id_rs1_re, id_rs1, id_rs2_re, id_rs2, id_rd_we, id_rd, id_ebreak,
    output ex_redirect, mem_busy, wb_valid, wb_we, wb_rd,
    input  stall_if_id, bubble_id_ex, flush_if_id, freeze, halt, busy_vec
  );

  modport slave (
    input  id_valid, id_rs1_re, id_rs1, id_rs2_re, id_rs2, id_rd_we, id_rd, id_ebreak,
    input  ex_redirect, mem_busy, wb_valid, wb_we, wb_rd,
    output stall_if_id, bubble_id_ex, flush_if_id, freeze, halt, busy_vec
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Register scoreboard plus run/drain/halt sequencer for the 5-stage core.
// state     | meaning
// ST_RUN    | normal issue, hazards resolved by stall/bubble
// ST_DRAIN  | ebreak issued, no further issue until in-flight count empties
// ST_HALTED | pipeline empty, halt asserted until reset
module pipe_ctrl #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 3
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             wb_clr, pend_rs1, pend_rs2, hazard, issue;

  // A write-first register file lets a same-cycle writeback satisfy the read.
  always_comb begin
    wb_clr   = bus.wb_valid & bus.wb_we;
    pend_rs1 = (bus.id_rs1 != 5'd0) & busy_q[bus.id_rs1] &
               ~(WB_BYPASS & wb_clr & (bus.wb_rd == bus.id_rs1));
    pend_rs2 = (bus.id_rs2 != 5'd0) & busy_q[bus.id_rs2] &
               ~(WB_BYPASS & wb_clr & (bus.wb_rd == bus.id_rs2));
    hazard   = bus.id_valid & ((bus.id_rs1_re & pend_rs1) | (bus.id_rs2_re & pend_rs2));
    issue    = (state_q == ST_RUN) & bus.id_valid & ~hazard & ~bus.ex_redirect & ~bus.mem_busy;
  end

  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    cnt_d            = cnt_q;
    bus.stall_if_id  = 1'b0;
    bus.bubble_id_ex = 1'b0;
    bus.flush_if_id  = 1'b0;
    bus.freeze       = 1'b0;

    if (bus.mem_busy) begin
      bus.freeze      = 1'b1;
      bus.stall_if_id = 1'b1;
    end else if (state_q != ST_RUN) begin
      bus.stall_if_id  = 1'b1;
      bus.bubble_id_ex = 1'b1;
      bus.flush_if_id  = bus.ex_redirect;
    end else if (bus.ex_redirect) begin
      bus.flush_if_id  = 1'b1;
      bus.bubble_id_ex = 1'b1;
    end else if (hazard) begin
      bus.stall_if_id  = 1'b1;
      bus.bubble_id_ex = 1'b1;
    end

    // Clear before set so a same-index issue wins over the retire.
    if (wb_clr) busy_d[bus.wb_rd] = 1'b0;
    if (issue & bus.id_rd_we) busy_d[bus.id_rd] = 1'b1;
    busy_d[0] = 1'b0;

    case ({issue, bus.wb_valid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_RUN: begin
        if (issue & bus.id_ebreak) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (~bus.mem_busy &
            ((cnt_q == '0) | ((cnt_q == CNT_W'(1)) & bus.wb_valid))) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase

    halt_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.halt     = halt_q;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: one instance with write-first bypass and one without, each checked
// every cycle against an in-order in-flight queue model, plus directed literal scenarios.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       id_valid;
    logic       rs1_re;
    logic [4:0] rs1;
    logic       rs2_re;
    logic [4:0] rs2;
    logic       rd_we;
    logic [4:0] rd;
    logic       ebreak;
    logic       redirect;
    logic       mem_busy;
    logic       wb_valid;
    logic       wb_we;
    logic [4:0] wb_rd;
  } stim_t;

  typedef struct {
    int rd;
    bit we;
    int cyc;
  } ent_t;

  localparam int CMAX = 7;

  stim_t       s       [2];
  logic        stall_o [2];
  logic        bub_o   [2];
  logic        flush_o [2];
  logic        frz_o   [2];
  logic        halt_o  [2];
  logic [31:0] busy_o  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_ctrl_if bus ();
    assign bus.id_valid    = s[g].id_valid;
    assign bus.id_rs1_re   = s[g].rs1_re;
    assign bus.id_rs1      = s[g].rs1;
    assign bus.id_rs2_re   = s[g].rs2_re;
    assign bus.id_rs2      = s[g].rs2;
    assign bus.id_rd_we    = s[g].rd_we;
    assign bus.id_rd       = s[g].rd;
    assign bus.id_ebreak   = s[g].ebreak;
    assign bus.ex_redirect = s[g].redirect;
    assign bus.mem_busy    = s[g].mem_busy;
    assign bus.wb_valid    = s[g].wb_valid;
    assign bus.wb_we       = s[g].wb_we;
    assign bus.wb_rd       = s[g].wb_rd;
    assign stall_o[g]      = bus.stall_if_id;
    assign bub_o[g]        = bus.bubble_id_ex;
    assign flush_o[g]      = bus.flush_if_id;
    assign frz_o[g]        = bus.freeze;
    assign halt_o[g]       = bus.halt;
    assign busy_o[g]       = bus.busy_vec;
    pipe_ctrl #(.WB_BYPASS(g == 1), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  // Model: 0 = running, 1 = draining, 2 = halted; instance 1 has the bypass.
  ent_t        inflight [2][$];
  logic [31:0] m_busy   [2] = '{32'd0, 32'd0};
  int          m_cnt    [2] = '{0, 0};
  int          m_st     [2] = '{0, 0};
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  function automatic bit pend(int k, logic [4:0] r, stim_t x);
    if (r == 5'd0 || !m_busy[k][r]) return 1'b0;
    if (k == 1 && x.wb_valid && x.wb_we && x.wb_rd == r) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    stim_t x;
    bit    hz, iss, e_stall, e_bub, e_fl, e_frz;
    #1;
    for (int k = 0; k < 2; k++) begin
      x  = s[k];
      hz = x.id_valid && ((x.rs1_re && pend(k, x.rs1, x)) || (x.rs2_re && pend(k, x.rs2, x)));
      e_stall = 0; e_bub = 0; e_fl = 0; e_frz = 0;
      if (x.mem_busy) begin
        e_frz = 1; e_stall = 1;
      end else if (m_st[k] != 0) begin
        e_stall = 1; e_bub = 1; e_fl = x.redirect;
      end else if (x.redirect) begin
        e_fl = 1; e_bub = 1;
      end else if (hz) begin
        e_stall = 1; e_bub = 1;
      end
      chk("stall_if_id",  k, 32'(stall_o[k]), 32'(e_stall));
      chk("bubble_id_ex", k, 32'(bub_o[k]),   32'(e_bub));
      chk("flush_if_id",  k, 32'(flush_o[k]), 32'(e_fl));
      chk("freeze",       k, 32'(frz_o[k]),   32'(e_frz));
      chk("halt",         k, 32'(halt_o[k]),  32'(m_st[k] == 2));
      chk("busy_vec",     k, busy_o[k],       m_busy[k]);

      iss = (m_st[k] == 0) && x.id_valid && !hz && !x.redirect && !x.mem_busy;
      if (rst) begin
        m_busy[k] = '0; m_cnt[k] = 0; m_st[k] = 0;
        inflight[k].delete();
      end else begin
        if (x.wb_valid) begin
          if (x.wb_we) m_busy[k][x.wb_rd] = 1'b0;
          if (inflight[k].size() > 0) void'(inflight[k].pop_front());
        end
        if (iss) begin
          if (x.rd_we && x.rd != 5'd0) m_busy[k][x.rd] = 1'b1;
          inflight[k].push_back('{rd: int'(x.rd), we: x.rd_we, cyc: cyc});
        end
        if (m_st[k] == 1 && !x.mem_busy && (m_cnt[k] == 0 || (m_cnt[k] == 1 && x.wb_valid)))
          m_st[k] = 2;
        else if (m_st[k] == 0 && iss && x.ebreak)
          m_st[k] = 1;
        m_cnt[k] = m_cnt[k] + int'(iss) - int'(x.wb_valid);
        if (m_cnt[k] < 0 || m_cnt[k] > CMAX) begin
          n_errors++;
          $display("FAIL count_range dut%0d cyc %0d: got %0d required 0..%0d", k, cyc, m_cnt[k], CMAX);
        end
      end
    end
    cyc++;
  end

  function automatic stim_t wr(int rd);
    stim_t x = '0;
    x.id_valid = 1'b1; x.rd_we = 1'b1; x.rd = 5'(rd);
    return x;
  endfunction

  function automatic stim_t ret(bit we, int rd);
    stim_t x = '0;
    x.wb_valid = 1'b1; x.wb_we = we; x.wb_rd = 5'(rd);
    return x;
  endfunction

  function automatic stim_t rand_stim(int k);
    stim_t x;
    x.id_valid = ($urandom_range(0, 3) != 0) && (m_cnt[k] < CMAX);
    x.rs1_re   = 1'($urandom_range(0, 1));
    x.rs1      = 5'($urandom_range(0, 7));
    x.rs2_re   = 1'($urandom_range(0, 1));
    x.rs2      = 5'($urandom_range(0, 7));
    x.rd_we    = 1'($urandom_range(0, 1));
    x.rd       = 5'($urandom_range(0, 7));
    x.ebreak   = ($urandom_range(0, 29) == 0);
    x.redirect = ($urandom_range(0, 7) == 0);
    x.mem_busy = ($urandom_range(0, 9) == 0);
    if (inflight[k].size() > 0 && cyc - inflight[k][0].cyc >= 2 && $urandom_range(0, 1) == 1) begin
      x.wb_valid = 1'b1;
      x.wb_we    = inflight[k][0].we;
      x.wb_rd    = 5'(inflight[k][0].rd);
    end else begin
      x.wb_valid = 1'b0;
      x.wb_we    = 1'($urandom_range(0, 1));
      x.wb_rd    = 5'($urandom_range(0, 7));
    end
    return x;
  endfunction

  initial begin
    stim_t dep;
    int    nst [2];
    bit    dn  [2];
    s[0] = '0; s[1] = '0;
    repeat (2) @(negedge clk);
    @(negedge clk); rst = 1'b0; #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset_halt",  k, 32'(halt_o[k]),  0);
      chk("reset_busy",  k, busy_o[k],       0);
      chk("reset_stall", k, 32'(stall_o[k]), 0);
    end

    // RAW on x5 with writeback four cycles after issue.
    @(negedge clk); s[0] = wr(5); s[1] = wr(5); #2;
    for (int k = 0; k < 2; k++) chk("issue_x5_stall", k, 32'(stall_o[k]), 0);
    dep = wr(6); dep.rs1_re = 1'b1; dep.rs1 = 5'd5;
    nst = '{0, 0}; dn = '{0, 0};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        s[k] = dn[k] ? stim_t'('0) : dep;
        if (c == 4) begin s[k].wb_valid = 1'b1; s[k].wb_we = 1'b1; s[k].wb_rd = 5'd5; end
      end
      #2;
      for (int k = 0; k < 2; k++)
        if (!dn[k]) begin
          if (stall_o[k]) nst[k]++;
          else dn[k] = 1'b1;
        end
      if (c == 5) for (int k = 0; k < 2; k++) chk("busy5_cleared", k, 32'(busy_o[k][5]), 0);
    end
    chk("raw_stalls_nobypass", 0, nst[0], 4);
    chk("raw_stalls_bypass",   1, nst[1], 3);
    @(negedge clk); s[0] = ret(1, 6); s[1] = ret(1, 6);

    // x0 is never tracked.
    @(negedge clk); s[0] = wr(0); s[1] = wr(0);
    @(negedge clk); dep = '0; dep.id_valid = 1'b1; dep.rs1_re = 1'b1;
    s[0] = dep; s[1] = dep; #2;
    for (int k = 0; k < 2; k++) begin
      chk("x0_stall", k, 32'(stall_o[k]), 0);
      chk("x0_busy",  k, busy_o[k],       0);
    end
    @(negedge clk); s[0] = ret(1, 0); s[1] = ret(1, 0);
    @(negedge clk); s[0] = ret(0, 0); s[1] = ret(0, 0);

    // Redirect outranks a hazard and the squashed instruction leaves no busy bit.
    @(negedge clk); s[0] = wr(9); s[1] = wr(9);
    @(negedge clk); dep = wr(10); dep.rs1_re = 1'b1; dep.rs1 = 5'd9; dep.redirect = 1'b1;
    s[0] = dep; s[1] = dep; #2;
    for (int k = 0; k < 2; k++) begin
      chk("redir_flush",  k, 32'(flush_o[k]), 1);
      chk("redir_bubble", k, 32'(bub_o[k]),   1);
      chk("redir_stall",  k, 32'(stall_o[k]), 0);
    end
    @(negedge clk); s[0] = '0; s[1] = '0; #2;
    for (int k = 0; k < 2; k++) begin
      chk("redir_busy10", k, 32'(busy_o[k][10]), 0);
      chk("redir_busy9",  k, 32'(busy_o[k][9]),  1);
    end
    @(negedge clk); s[0] = ret(1, 9); s[1] = ret(1, 9);

    // Same-index issue and retire: the set survives.
    @(negedge clk); s[0] = wr(7); s[1] = wr(7);
    @(negedge clk); s[0] = '0; s[1] = '0;
    @(negedge clk); dep = wr(7); dep.wb_valid = 1'b1; dep.wb_we = 1'b1; dep.wb_rd = 5'd7;
    s[0] = dep; s[1] = dep;
    @(negedge clk); s[0] = '0; s[1] = '0; #2;
    for (int k = 0; k < 2; k++) chk("same_idx_busy7", k, 32'(busy_o[k][7]), 1);
    @(negedge clk); s[0] = ret(1, 7); s[1] = ret(1, 7);
    @(negedge clk); s[0] = '0; s[1] = '0; #2;
    for (int k = 0; k < 2; k++) chk("busy7_final", k, 32'(busy_o[k][7]), 0);

    // ebreak with two instructions ahead of it: halt follows the third retire.
    @(negedge clk); s[0] = wr(11); s[1] = wr(11);
    @(negedge clk); s[0] = wr(12); s[1] = wr(12);
    @(negedge clk); dep = '0; dep.id_valid = 1'b1; dep.ebreak = 1'b1;
    s[0] = dep; s[1] = dep; #2;
    for (int k = 0; k < 2; k++) chk("ebreak_issue_stall", k, 32'(stall_o[k]), 0);
    @(negedge clk); s[0] = '0; s[1] = '0; #2;
    for (int k = 0; k < 2; k++) begin
      chk("drain_stall",  k, 32'(stall_o[k]), 1);
      chk("drain_bubble", k, 32'(bub_o[k]),   1);
      chk("drain_halt",   k, 32'(halt_o[k]),  0);
    end
    @(negedge clk); s[0] = ret(1, 11); s[1] = ret(1, 11); #2;
    for (int k = 0; k < 2; k++) chk("drain_halt_wb1", k, 32'(halt_o[k]), 0);
    @(negedge clk); s[0] = ret(1, 12); s[1] = ret(1, 12); #2;
    for (int k = 0; k < 2; k++) chk("drain_halt_wb2", k, 32'(halt_o[k]), 0);
    @(negedge clk); s[0] = ret(0, 0); s[1] = ret(0, 0); #2;
    for (int k = 0; k < 2; k++) chk("drain_halt_wb3", k, 32'(halt_o[k]), 0);
    @(negedge clk); s[0] = '0; s[1] = '0; #2;
    for (int k = 0; k < 2; k++) begin
      chk("halted_halt",  k, 32'(halt_o[k]),  1);
      chk("halted_stall", k, 32'(stall_o[k]), 1);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; s[0] = wr(3); s[1] = wr(3); #2;
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_halt",  k, 32'(halt_o[k]),  0);
      chk("post_rst_busy",  k, busy_o[k],       0);
      chk("post_rst_stall", k, 32'(stall_o[k]), 0);
    end

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (m_st[0] == 2 || m_st[1] == 2) rst = ($urandom_range(0, 3) == 0);
      else                              rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) s[k] = rand_stim(k);
    end
    @(negedge clk); rst = 1'b0; s[0] = '0; s[1] = '0;
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV64 core: a register scoreboard plus a run/drain/halt state machine. It sits beside the decode stage and ID/EX register. It tells IF and IF/ID when to hold, tells ID/EX when to load a bubble (NOP op, write-disable), and squashes the fetched instruction on a control-flow redirect. It also drains the pipeline on ebreak before raising halt to the simulation environment.

## Interface
Parameters:
- WB_BYPASS, 1: 1 = register file is write-first, so a register whose writeback occurs this cycle is not a hazard.
- CNT_W, 3: width of the in-flight instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1_re  in  1  ID reads rs1
- id_rs1  in  5  rs1 index
- id_rs2_re  in  1  ID reads rs2
- id_rs2  in  5  rs2 index
- id_rd_we  in  1  ID instruction writes rd
- id_rd  in  5  rd index
- id_ebreak  in  1  ID instruction is ebreak (32'h00100073)
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- mem_busy  in  1  MEM multi-cycle access pending; freezes whole pipe
- wb_valid  in  1  an instruction retires this cycle
- wb_we  in  1  retiring instruction writes rd
- wb_rd  in  5  retiring rd index
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_id_ex  out  1  load NOP/write-disable into ID/EX
- flush_if_id  out  1  replace IF/ID contents with NOP
- freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- halt  out  1  core halted (registered)
- busy_vec  out  32  scoreboard, bit i = write to xi outstanding

## Operation
- States: RUN, DRAIN, HALTED. Reset -> RUN, busy_vec=0, count=0, halt=0.
- hazard = id_valid & ((id_rs1_re & pend(id_rs1)) | (id_rs2_re & pend(id_rs2))). pend(r) = busy[r] & ~(WB_BYPASS & wb_valid & wb_we & wb_rd==r). r=0 never pending.
- issue = state==RUN & id_valid & ~hazard & ~ex_redirect & ~mem_busy.
- Issue with id_rd_we & id_rd!=0 sets busy[id_rd] next cycle.
- Retire with wb_we clears busy[wb_rd]. If issue sets and retire clears the same index in one cycle, set wins.
- count: +1 on issue, -1 on wb_valid, unchanged when both or neither. Never wraps; overflow/underflow is a bench assertion failure.
- Priority, highest first:
  - mem_busy: freeze=1, stall_if_id=1, bubble_id_ex=0, flush_if_id=0.
  - ex_redirect: flush_if_id=1, bubble_id_ex=1, stall_if_id=0.
  - hazard: stall_if_id=1, bubble_id_ex=1.
  - otherwise: all 0.
- ebreak: when issue & id_ebreak, go RUN->DRAIN. The ebreak itself counts in count.
- DRAIN: stall_if_id=1, bubble_id_ex=1, and no further issue. Go DRAIN->HALTED when count==0, or when count==1 & wb_valid.
- HALTED: halt=1, stall_if_id=1, bubble_id_ex=1. Leave only via rst.
- An ebreak squashed by ex_redirect or held by a hazard does not trigger DRAIN.
- rst mid-DRAIN or mid-hazard: all state cleared next edge, no residue.

## Timing
- stall_if_id, bubble_id_ex, flush_if_id and freeze are combinational from inputs and registered state, with 0-cycle latency.
- busy_vec, count, state and halt update at the clk edge.
- Back-to-back dependent instructions with a 3-stage distance to WB give 3 bubble cycles with WB_BYPASS=1, and 4 with WB_BYPASS=0.
- halt rises on the edge following the cycle in which the last retire makes count zero.
- While mem_busy is high, busy_vec, count and state are held, except that retire updates still apply if wb_valid is asserted.

## Test plan
- Hazard, bypass on: issue addi x5 (rd_we, rd=5), then ID reads rs1=5 -> stall_if_id=bubble_id_ex=1 until the wb cycle for x5; that wb cycle itself has no stall; busy_vec[5] clears the edge after.
- Hazard, bypass off: same sequence with WB_BYPASS=0 -> one extra stall cycle.
- x0: issue with rd=0, then read rs1=0 -> busy_vec stays 0, no stall.
- Redirect vs hazard: ex_redirect=1 while hazard=1 -> flush_if_id=1, bubble_id_ex=1, stall_if_id=0; the squashed instruction sets no busy bit.
- Same-index set and retire: wb clears x7 in the same cycle an issue sets x7 -> busy_vec[7]=1 after the edge.
- ebreak drain: 2 instructions in flight, then issue ebreak -> state DRAIN, count=3. After 3 wb_valid pulses, halt=1 on the next edge. Asserting rst then gives halt=0, busy_vec=0, state RUN.
